// File: rtl/seq_mon_pkg.sv
// Shared state codes and constants for the detection window monitor.
// Imported by seq_hit_window_monitor.
package seq_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   function automatic int sat_max(input int w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/hit_qualifier.sv
// Hit qualification for the window monitor.
// HIT_EDGE_EN selects rising-edge qualification instead of level.
module hit_qualifier (
   input  logic clk,
   input  logic rst,
   input  logic hit_in,
   output logic hit_q
);

`ifdef HIT_EDGE_EN
   logic prev;

   // prev tracks the level in every state so a held level is never recounted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev <= 1'b0;
      else      prev <= hit_in;
   end

   assign hit_q = hit_in & ~prev;
`else
   logic unused_ports;

   assign unused_ports = clk ^ rst;
   assign hit_q        = hit_in;
`endif

endmodule

// File: rtl/seq_hit_window_monitor.sv
// Counts detector hits over back-to-back windows and reports per window.
// Build option: HIT_EDGE_EN counts only rising edges of hit_in.
module seq_hit_window_monitor
   import seq_mon_pkg::*;
#(
   parameter int WIN_CYCLES = 16,
   parameter int CNT_W      = 5,
   parameter int THRESH     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             hit_in,
   output logic [CNT_W-1:0] hit_count,
   output logic             count_valid,
   output logic             alarm,
   output logic             win_active,
   output logic [1:0]       curr_state
);

   localparam int TW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

   localparam logic [TW-1:0]    TMR_LAST = TW'(WIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACC_MAX  = CNT_W'(sat_max(CNT_W));
   localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);

   state_t           state;
   state_t           state_nx;
   logic [TW-1:0]    timer;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_nx;
   logic             hit_q;
   logic             counted;
   logic             win_end;

   hit_qualifier u_qual (
      .clk    (clk),
      .rst    (rst),
      .hit_in (hit_in),
      .hit_q  (hit_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = ST_IDLE;
      if (!clr) begin
         case (state)
            ST_IDLE:  state_nx = en ? ST_RUN : ST_IDLE;
            ST_RUN:   state_nx = en ? ST_RUN : ST_PAUSE;
            ST_PAUSE: state_nx = en ? ST_RUN : ST_PAUSE;
            default:  state_nx = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      win_active = (state == ST_RUN);
   end

   assign curr_state = state;

   assign counted = (state == ST_RUN) && en;
   assign win_end = counted && (timer == TMR_LAST);

   always_comb begin
      acc_nx = acc;
      if (hit_q && (acc != ACC_MAX)) acc_nx = acc + 1'b1;
   end

   // acc_nx already folds in the final cycle's hit at window end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc         <= '0;
         timer       <= '0;
         hit_count   <= '0;
         count_valid <= 1'b0;
         alarm       <= 1'b0;
      end else if (clr) begin
         acc         <= '0;
         timer       <= '0;
         hit_count   <= '0;
         count_valid <= 1'b0;
         alarm       <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         if (state == ST_IDLE) begin
            acc   <= '0;
            timer <= '0;
         end else if (win_end) begin
            hit_count   <= acc_nx;
            count_valid <= 1'b1;
            alarm       <= (acc_nx >= THR);
            acc         <= '0;
            timer       <= '0;
         end else if (counted) begin
            acc   <= acc_nx;
            timer <= timer + 1'b1;
         end
      end
   end

endmodule
